mips_bus_fabric: RTL
====================

MIPS_BUS_FABRIC -- requirements
Module: mips_bus_fabric

Interface
REQ-001 The module SHALL have parameter N_SLV, default 4, giving the number of slave ports (legal 2..8).
REQ-002 The module SHALL have parameter SEL_LO, default 8, giving the lowest address bit of the slave-select field; the field is clog2(N_SLV) bits wide.
REQ-003 The module SHALL have parameter TIMEOUT, default 15, giving the maximum ACCESS cycles before abort (legal 1..255).
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 m_valid  input  1  master request strobe.
REQ-007 m_we  input  1  master write enable.
REQ-008 m_addr  input  32  master byte address.
REQ-009 m_wdata  input  32  master write data.
REQ-010 m_ready  output  1  one-cycle response-complete strobe.
REQ-011 m_rdata  output  32  read data, valid while m_ready=1.
REQ-012 m_err  output  1  error flag, valid while m_ready=1.
REQ-013 s_sel  output  N_SLV  one-hot slave select.
REQ-014 s_we  output  1  broadcast write enable, gated by s_sel.
REQ-015 s_addr  output  32  broadcast latched address.
REQ-016 s_wdata  output  32  broadcast latched write data.
REQ-017 s_rdata  input  32*N_SLV  flattened slave read data, slave i at bits [32i+31:32i].
REQ-018 s_ack  input  N_SLV  per-slave completion acknowledge.
REQ-019 err_cnt  output  8  saturating count of error responses.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-021 In IDLE with m_valid=1, the fabric SHALL latch m_addr, m_we, m_wdata and compute idx = m_addr[SEL_LO+clog2(N_SLV)-1:SEL_LO].
REQ-022 If idx < N_SLV, next state SHALL be ACCESS; else next state SHALL be RESP with m_err=1 and m_rdata=32'hDEADBEEF (unmapped).
REQ-023 In ACCESS, s_sel SHALL be one-hot at bit idx, s_we equal to the latched m_we; outside ACCESS s_sel=0 and s_we=0.
REQ-024 In ACCESS, s_ack[idx]=1 SHALL capture s_rdata slice idx into m_rdata (writes capture 0), clear error, go to RESP.
REQ-025 s_ack bits other than idx SHALL be ignored.
REQ-026 RESP SHALL last exactly one cycle with m_ready=1, then return to IDLE; m_valid sampled in RESP is ignored.
REQ-027 Zero-wait slave (ack in first ACCESS cycle) SHALL give m_ready exactly 2 cycles after the m_valid sampling edge.
REQ-028 Master SHALL hold m_valid until m_ready; fabric ignores master inputs outside IDLE.
REQ-029 m_rdata and m_err SHALL hold last response values outside RESP.
REQ-030 err_cnt SHALL increment on each RESP with m_err=1 and saturate at 255.

Reset
REQ-031 rst=0 at a rising edge SHALL force IDLE, s_sel=0, s_we=0, s_addr=0, s_wdata=0, m_ready=0, m_err=0, m_rdata=0, err_cnt=0, timeout counter=0.
REQ-032 Reset mid-ACCESS SHALL abort the transaction with no m_ready pulse.

Configuration
REQ-033 With BUS_TIMEOUT_EN defined, an ACCESS-cycle counter SHALL abort after TIMEOUT cycles without s_ack[idx]: go to RESP with m_err=1, m_rdata=32'hDEADBEEF; ack in the same cycle as expiry wins.
REQ-034 Without BUS_TIMEOUT_EN, ACCESS SHALL wait indefinitely for s_ack[idx] and no counter SHALL be present.

Verification
REQ-035 Read slave 2, m_addr=32'h0000_0204, ack in first ACCESS cycle, s_rdata slice 2=32'h1234_5678 -> s_sel=4'b0100 one cycle, m_ready 2 cycles after request, m_rdata=32'h1234_5678, m_err=0.
REQ-036 Write slave 1, m_addr=32'h0000_0100, m_wdata=32'hA5A5_A5A5, ack after 3 cycles -> s_we=1, s_wdata=32'hA5A5_A5A5 for 3 ACCESS cycles, m_ready 1 cycle, m_err=0.
REQ-037 N_SLV=3, m_addr=32'h0000_0300 -> no s_sel, m_ready next cycle, m_err=1, m_rdata=32'hDEADBEEF, err_cnt=1.
REQ-038 BUS_TIMEOUT_EN, TIMEOUT=15, slave 0 never acks -> m_ready after 15 ACCESS cycles, m_err=1; without macro m_ready never asserts.
REQ-039 Assert rst=0 in second ACCESS cycle -> next cycle s_sel=0, no m_ready, err_cnt=0; 256 unmapped requests -> err_cnt=255.

Source files
------------

// File: rtl/mips_bus_fabric.sv
// mips_bus_fabric: single-master, N_SLV-slave bus fabric with address decode.
// The slave is selected by the address field m_addr[SEL_LO +: clog2(N_SLV)].
// Select values that have no slave get an immediate DEADBEEF error response.
// Optional feature macro BUS_TIMEOUT_EN: aborts an ACCESS that waits too long for the slave.
//   Defined:   an ACCESS that sees no acknowledge for TIMEOUT cycles ends with an error.
//   Undefined: an ACCESS waits for the slave acknowledge forever.
module mips_bus_fabric #(
  parameter int N_SLV   = 4,
  parameter int SEL_LO  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_valid,
  input  logic                  m_we,
  input  logic [31:0]           m_addr,
  input  logic [31:0]           m_wdata,
  output logic                  m_ready,
  output logic [31:0]           m_rdata,
  output logic                  m_err,
  output logic [N_SLV-1:0]      s_sel,
  output logic                  s_we,
  output logic [31:0]           s_addr,
  output logic [31:0]           s_wdata,
  input  logic [32*N_SLV-1:0]   s_rdata,
  input  logic [N_SLV-1:0]      s_ack,
  output logic [7:0]            err_cnt
);

  localparam int SW = $clog2(N_SLV);
  localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r;
  logic [SW-1:0]     idx_r;
  logic              we_r;
  logic [SW-1:0]     req_idx_s;
  logic              req_mapped_s;
  logic [31:0]       sel_rdata_s;
  logic              sel_ack_s;
`ifdef BUS_TIMEOUT_EN
  logic [7:0]        tmo_cnt_r;
`endif

  // Saturating increment for the error counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // One-hot slave select from a decoded index.
  function automatic logic [N_SLV-1:0] onehot(input logic [SW-1:0] i);
    onehot = {{(N_SLV-1){1'b0}}, 1'b1} << i;
  endfunction

  // Decode the incoming request and pick the addressed slave's data and acknowledge.
  always_comb begin
    req_idx_s    = m_addr[SEL_LO +: SW];
    req_mapped_s = (int'(req_idx_s) < N_SLV);
    sel_rdata_s  = 32'h0000_0000;
    sel_ack_s    = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      sel_rdata_s = sel_rdata_s | (s_rdata[32*i +: 32] & {32{int'(idx_r) == i}});
      sel_ack_s   = sel_ack_s | (s_ack[i] & (int'(idx_r) == i));
    end
  end

  // Transaction FSM with all bus-facing outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
      we_r    <= 1'b0;
      s_sel   <= '0;
      s_we    <= 1'b0;
      s_addr  <= 32'h0000_0000;
      s_wdata <= 32'h0000_0000;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= 32'h0000_0000;
      err_cnt <= 8'd0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_r <= 8'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          m_ready <= 1'b0;
          if (m_valid) begin
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            we_r    <= m_we;
            idx_r   <= req_idx_s;
            if (req_mapped_s) begin
              state_r <= ACCESS;
              s_sel   <= onehot(req_idx_s);
              s_we    <= m_we;
`ifdef BUS_TIMEOUT_EN
              tmo_cnt_r <= 8'd0;
`endif
            end else begin
              // Unmapped select: answer at once with an error.
              state_r <= RESP;
              m_ready <= 1'b1;
              m_err   <= 1'b1;
              m_rdata <= UNMAPPED_DATA;
              err_cnt <= sat_inc(err_cnt);
            end
          end
        end
        ACCESS: begin
          if (sel_ack_s) begin
            // An acknowledge beats a timeout that expires in the same cycle.
            state_r <= RESP;
            m_ready <= 1'b1;
            m_err   <= 1'b0;
            m_rdata <= we_r ? 32'h0000_0000 : sel_rdata_s;
            s_sel   <= '0;
            s_we    <= 1'b0;
          end
`ifdef BUS_TIMEOUT_EN
          else if (tmo_cnt_r == 8'(TIMEOUT - 1)) begin
            state_r <= RESP;
            m_ready <= 1'b1;
            m_err   <= 1'b1;
            m_rdata <= UNMAPPED_DATA;
            s_sel   <= '0;
            s_we    <= 1'b0;
            err_cnt <= sat_inc(err_cnt);
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
`endif
        end
        RESP: begin
          // One-cycle response. The master's request is not looked at here.
          state_r <= IDLE;
          m_ready <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          m_ready <= 1'b0;
          s_sel   <= '0;
          s_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule
